ahb_mem_arbiter: RTL and testbench
==================================

# ahb_mem_arbiter

Round-robin arbiter and transfer sequencer that shares one AHB memory slave port between `NUM_REQ` simple requesters. It accepts one request at a time, issues it as a single NONSEQ transfer, and waits out the slave's wait states. It then returns read data or an error to the granted requester. It sits between processor/DMA-side request ports and the memory slave, and is the only master driving that slave.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `TIMEOUT`, 64: maximum HREADY-low cycles per transfer before abort (≥4).
- `HCLK` in 1: clock, rising edge.
- `HRESET` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: request pending, one bit per requester; held until `req_ready`.
- `req_write` in NUM_REQ: 1 = write.
- `req_addr` in NUM_REQ*32: byte address; requester i uses bits [32i+31:32i].
- `req_wdata` in NUM_REQ*32: write data, packed the same way as `req_addr`.
- `req_size` in NUM_REQ*3: HSIZE code (000 byte, 001 half, 010 word).
- `req_ready` out NUM_REQ: one-cycle acceptance pulse for the granted requester.
- `rsp_valid` out NUM_REQ: one-cycle completion pulse to the owner.
- `rsp_rdata` out 32: read data, valid with `rsp_valid`; 0 for writes.
- `rsp_err` out 1: qualifies `rsp_valid`; 1 = timeout or HRESP≠OKAY.
- `arb_busy` out 1: high in every state except IDLE.
- `HSEL`, `HTRANS[1:0]`, `HADDR[31:0]`, `HWRITE`, `HSIZE[2:0]`, `HWDATA[31:0]` out: AHB master signals to the slave.
- `HRDATA[31:0]`, `HREADY`, `HRESP[1:0]` in: from the slave.

## Operation
- FSM states:
  - **IDLE:** If any `req_valid` is set and HREADY=1, grant the requester by round-robin. Search starts at `last_grant+1` modulo NUM_REQ. Pulse `req_ready[g]`, latch addr/wdata/write/size, record the owner, set `last_grant<=g`, go to ADDR.
  - **ADDR:** Drive HSEL=1, HTRANS=NONSEQ (10), and the latched HADDR/HWRITE/HSIZE. Drive HWDATA in this same cycle, because the slave samples write data with the address. Go to WAIT.
  - **WAIT:** Drive HSEL=1, HTRANS=IDLE (00), and keep HADDR/HSIZE/HWRITE held, because the slave muxes HRDATA by the live HSIZE. Increment `to_cnt` each cycle.
    - If HREADY=1 and `to_cnt`≥1, latch HRDATA (reads only) and HRESP≠00 into `err`, then go to DONE.
    - If `to_cnt` reaches TIMEOUT, set `err=1` and `rdata=0`, then go to DONE.
    - The first WAIT cycle is always ignored, because the slave raises busy only after capture.
  - **DONE:** Pulse `rsp_valid[owner]` with `rsp_rdata`/`rsp_err`, clear `to_cnt`, go to IDLE.
- Only one outstanding transfer at a time; no bursts, SEQ, or BUSY are ever issued.
- Requests arriving while not in IDLE wait; `req_valid` deassertion before `req_ready` withdraws the request.
- `last_grant` resets to NUM_REQ-1, so requester 0 wins the first arbitration.
- `to_cnt` width is clog2(TIMEOUT+1) and saturates at TIMEOUT.
- Outside ADDR/WAIT: HSEL=0, HTRANS=00, and the remaining AHB outputs hold their last values.

## Timing
- Reset values: state IDLE, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `arb_busy`=0, HSEL=0, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=010, HWDATA=0.
- Reset asserted mid-transfer returns to IDLE immediately with no `rsp_valid` pulse. The requester must reissue the request.
- Acceptance is the cycle in which `req_ready` pulses (cycle 0). ADDR is cycle 1.
- With slave latency L, HREADY returns high at cycle L+2 and `rsp_valid` pulses at cycle L+3. For L=2, `rsp_valid` is at cycle 5.
- The next grant can occur at the earliest in the cycle after DONE, at cycle L+4.
- All outputs are registered. `req_ready` and `rsp_valid` are never high for more than one cycle.
- Simultaneous requests are resolved in the same cycle; no fairness starvation occurs. With all NUM_REQ requesters continuously requesting, each is granted once per NUM_REQ grants.

## Test plan
- **Single word write then read (L=2):** req 0 writes 0xDEADBEEF to 0x10, then reads 0x10. Required response: `rsp_valid[0]` at cycle 5 after each `req_ready`; read `rsp_rdata`=0xDEADBEEF; `rsp_err`=0.
- **Byte read:** word 0x11223344 at 0x20, read with size 000 at 0x22. Required response: `rsp_rdata`=0x00000022.
- **Contention:** req 0 and req 1 held continuously for 6 transfers. Required response: grants alternate 0,1,0,1,0,1; exactly one `rsp_valid` per grant, routed to the correct bit.
- **Timeout:** slave model holds HREADY low forever. Required response: `rsp_err`=1 and `rsp_rdata`=0 after exactly TIMEOUT WAIT cycles; FSM returns to IDLE; the next request is serviced normally.
- **HRESP error:** slave returns HRESP=01 on completion. Required response: `rsp_valid` with `rsp_err`=1.
- **Reset mid-WAIT:** assert HRESET during WAIT. Required response: all outputs take their reset values immediately with no `rsp_valid`; after release, req 0 wins the first arbitration.

Source files
------------

// File: rtl/ahb_mem_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ simple requesters onto one AHB
// memory slave, one single NONSEQ transfer at a time, with a wait-state timeout.

// Per-requester handshake pulses; one instance per requester.
module ahb_mem_arbiter_lane (
  input  logic HCLK,
  input  logic HRESET,
  input  logic gnt,
  input  logic done,
  output logic req_ready,
  output logic rsp_valid
);
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      req_ready <= gnt;
      rsp_valid <= done;
    end
  end
endmodule

module ahb_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0] req_wdata,
  input  logic [NUM_REQ-1:0][2:0]  req_size,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic                     arb_busy,
  output logic                     HSEL,
  output logic [1:0]               HTRANS,
  output logic [31:0]              HADDR,
  output logic                     HWRITE,
  output logic [2:0]               HSIZE,
  output logic [31:0]              HWDATA,
  input  logic [31:0]              HRDATA,
  input  logic                     HREADY,
  input  logic [1:0]               HRESP
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [2:0]  size;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_DONE} state_t;

  state_t        state;
  req_t          cur;
  logic [IW-1:0] last_grant, owner, gnt_idx;
  logic [IW:0]   cand;
  logic          gnt_any, gnt_fire;
  logic [CW-1:0] to_cnt, cnt_nxt;
  logic          xfer_ok, xfer_to, rsp_fire;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!gnt_any && req_valid[cand[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
  end

  assign gnt_fire = (state == S_IDLE) && gnt_any && HREADY;

  // First WAIT cycle (to_cnt==0) is skipped: the slave only drops HREADY after capture.
  assign cnt_nxt  = (to_cnt == CW'(TIMEOUT)) ? to_cnt : to_cnt + CW'(1);
  assign xfer_ok  = (state == S_WAIT) && HREADY && (to_cnt != '0);
  assign xfer_to  = (state == S_WAIT) && !xfer_ok && (cnt_nxt == CW'(TIMEOUT));
  assign rsp_fire = xfer_ok || xfer_to;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= S_IDLE;
      cur        <= '0;
      owner      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      to_cnt     <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      arb_busy   <= 1'b0;
      HSEL       <= 1'b0;
      HTRANS     <= TR_IDLE;
      HADDR      <= '0;
      HWRITE     <= 1'b0;
      HSIZE      <= 3'b010;
      HWDATA     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_fire) begin
            cur        <= '{addr: req_addr[gnt_idx], wdata: req_wdata[gnt_idx],
                            write: req_write[gnt_idx], size: req_size[gnt_idx]};
            owner      <= gnt_idx;
            last_grant <= gnt_idx;
            arb_busy   <= 1'b1;
            state      <= S_ADDR;
          end
        end
        S_ADDR: begin
          // Write data goes out with the address phase; this slave samples both together.
          HSEL   <= 1'b1;
          HTRANS <= TR_NONSEQ;
          HADDR  <= cur.addr;
          HWRITE <= cur.write;
          HSIZE  <= cur.size;
          HWDATA <= cur.wdata;
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          HTRANS <= TR_IDLE;
          to_cnt <= cnt_nxt;
          if (xfer_ok) begin
            rsp_rdata <= cur.write ? 32'h0 : HRDATA;
            rsp_err   <= (HRESP != 2'b00);
            HSEL      <= 1'b0;
            state     <= S_DONE;
          end else if (xfer_to) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b1;
            HSEL      <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          to_cnt   <= '0;
          arb_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    ahb_mem_arbiter_lane u_lane (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .gnt       (gnt_fire && (gnt_idx == IW'(i))),
      .done      (rsp_fire && (owner == IW'(i))),
      .req_ready (req_ready[i]),
      .rsp_valid (rsp_valid[i])
    );
  end

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed bench: a small AHB slave model with programmable latency/fault mode,
// and a scoreboard that checks grant order, address phase and responses.
module tb_ahb_mem_arbiter;
  localparam int NR = 2;
  localparam int TO = 8;

  logic                HCLK, HRESET;
  logic [NR-1:0]       req_valid, req_write, req_ready, rsp_valid;
  logic [NR-1:0][31:0] req_addr, req_wdata;
  logic [NR-1:0][2:0]  req_size;
  logic [31:0]         rsp_rdata, HADDR, HWDATA, HRDATA;
  logic                rsp_err, arb_busy, HSEL, HWRITE, HREADY;
  logic [1:0]          HTRANS, HRESP;
  logic [2:0]          HSIZE;

  ahb_mem_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .arb_busy(arb_busy), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int tests = 0, fails = 0, cyc = 0, gnt_cyc = -10;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] mem [64];
  int          lat = 2, mode = 0;   // mode 0 normal, 1 hang, 2 HRESP error
  int          scnt;
  logic        pend;
  logic [31:0] s_addr;
  logic [2:0]  s_size;

  function automatic logic [31:0] rd(input logic [31:0] w, input logic [1:0] a, input logic [2:0] sz);
    logic [31:0] s;
    s = w >> {a, 3'b000};
    case (sz)
      3'b000:  return s & 32'hFF;
      3'b001:  return s & 32'hFFFF;
      default: return s;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] a, input logic [2:0] sz);
    logic [31:0] m;
    case (sz)
      3'b000:  m = 32'hFF << {a, 3'b000};
      3'b001:  m = 32'hFFFF << {a, 3'b000};
      default: m = 32'hFFFF_FFFF;
    endcase
    return (old & ~m) | (d & m);
  endfunction

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HREADY <= 1'b1; HRESP <= 2'b00; HRDATA <= '0; pend <= 1'b0; scnt <= 0;
      s_addr <= '0; s_size <= '0;
    end else if (HSEL && HTRANS == 2'b10) begin
      s_addr <= HADDR; s_size <= HSIZE; HRESP <= 2'b00;
      if (HWRITE) mem[HADDR[7:2]] <= merge(mem[HADDR[7:2]], HWDATA, HADDR[1:0], HSIZE);
      if (lat == 0 && mode != 1) begin
        HREADY <= 1'b1; HRDATA <= rd(mem[HADDR[7:2]], HADDR[1:0], HSIZE);
        HRESP  <= (mode == 2) ? 2'b01 : 2'b00; pend <= 1'b0;
      end else begin
        HREADY <= 1'b0; scnt <= lat; pend <= 1'b1;
      end
    end else if (pend) begin
      if (scnt > 1) scnt <= scnt - 1;
      else if (mode != 1) begin
        HREADY <= 1'b1; HRDATA <= rd(mem[s_addr[7:2]], s_addr[1:0], s_size);
        HRESP  <= (mode == 2) ? 2'b01 : 2'b00; pend <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          owner;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t exp_rsp[$];
  int   exp_gnt[$];

  initial begin
    forever begin
      @(negedge HCLK);
      if (!HRESET) begin
        if (req_ready != '0) begin
          if (exp_gnt.size() == 0) chk("unexpected_ready", 32'(req_ready), 32'h0);
          else chk("grant", 32'(req_ready), 32'(1 << exp_gnt.pop_front()));
          gnt_cyc = cyc;
        end
        if (cyc == gnt_cyc + 1 && exp_rsp.size() != 0) begin
          chk("addr_phase_htrans", 32'(HTRANS), 32'h2);
          chk("addr_phase_haddr", HADDR, exp_rsp[0].addr);
        end
        if (rsp_valid != '0) begin
          if (exp_rsp.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
          else begin
            exp_t e;
            e = exp_rsp.pop_front();
            chk("rsp_owner", 32'(rsp_valid), 32'(1 << e.owner));
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_latency", 32'(cyc - gnt_cyc), 32'(e.lat));
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic set_req(input int r, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] sz);
    req_write[r] = wr; req_addr[r] = a; req_wdata[r] = d; req_size[r] = sz;
  endtask

  task automatic expect_xfer(input int r, input logic [31:0] a, input logic [31:0] rdata,
                             input logic err, input int l);
    exp_t e;
    e.owner = r; e.addr = a; e.rdata = rdata; e.err = err; e.lat = l;
    exp_gnt.push_back(r);
    exp_rsp.push_back(e);
  endtask

  // Raise valid on every requester in mask until n acceptances have been seen.
  task automatic drive(input logic [NR-1:0] mask, input int n);
    int cnt = 0;
    req_valid = mask;
    for (int i = 0; i < 200 && cnt < n; i++) begin
      @(negedge HCLK);
      if (req_ready != '0) cnt++;
    end
    req_valid = '0;
    if (cnt != n) chk("ready_timeout", 32'(cnt), 32'(n));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && exp_rsp.size() != 0; i++) @(negedge HCLK);
    if (exp_rsp.size() != 0) begin
      chk("rsp_timeout", 32'(exp_rsp.size()), 32'h0);
      exp_rsp.delete();
      exp_gnt.delete();
    end
    @(negedge HCLK);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"},   32'(rsp_err), 32'h0);
    chk({tag, "_arb_busy"},  32'(arb_busy), 32'h0);
    chk({tag, "_hsel"},      32'(HSEL), 32'h0);
    chk({tag, "_htrans"},    32'(HTRANS), 32'h0);
    chk({tag, "_haddr"},     HADDR, 32'h0);
    chk({tag, "_hwrite"},    32'(HWRITE), 32'h0);
    chk({tag, "_hsize"},     32'(HSIZE), 32'h2);
    chk({tag, "_hwdata"},    HWDATA, 32'h0);
  endtask

  initial begin
    HRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_size = '0;
    #12;
    check_reset_vals("reset");
    @(negedge HCLK); HRESET = 1'b0;
    @(negedge HCLK);

    // word write then read, L=2 -> response 5 cycles after acceptance
    lat = 2;
    set_req(0, 1, 32'h10, 32'hDEADBEEF, 3'b010); expect_xfer(0, 32'h10, 32'h0, 0, 5);
    drive(2'b01, 1); wait_done();
    set_req(0, 0, 32'h10, 32'h0, 3'b010); expect_xfer(0, 32'h10, 32'hDEADBEEF, 0, 5);
    drive(2'b01, 1); wait_done();

    // byte read out of a word written by requester 1
    set_req(1, 1, 32'h20, 32'h11223344, 3'b010); expect_xfer(1, 32'h20, 32'h0, 0, 5);
    drive(2'b10, 1); wait_done();
    set_req(1, 0, 32'h22, 32'h0, 3'b000); expect_xfer(1, 32'h22, 32'h22, 0, 5);
    drive(2'b10, 1); wait_done();

    // contention: last winner was 1, so grants go 0,1,0,1,0,1
    set_req(0, 0, 32'h10, 32'h0, 3'b010);
    set_req(1, 0, 32'h20, 32'h0, 3'b010);
    for (int k = 0; k < 3; k++) begin
      expect_xfer(0, 32'h10, 32'hDEADBEEF, 0, 5);
      expect_xfer(1, 32'h20, 32'h11223344, 0, 5);
    end
    drive(2'b11, 6); wait_done();

    // other latencies: zero wait states and a long one
    lat = 0;
    set_req(0, 0, 32'h22, 32'h0, 3'b001); expect_xfer(0, 32'h22, 32'h1122, 0, 3);
    drive(2'b01, 1); wait_done();
    lat = 5;
    set_req(1, 0, 32'h10, 32'h0, 3'b010); expect_xfer(1, 32'h10, 32'hDEADBEEF, 0, 8);
    drive(2'b10, 1); wait_done();

    // timeout: slave never completes, error after TO wait cycles
    lat = 2; mode = 1;
    set_req(0, 0, 32'h10, 32'h0, 3'b010); expect_xfer(0, 32'h10, 32'h0, 1, TO + 1);
    drive(2'b01, 1); wait_done();
    mode = 0;
    chk("busy_after_timeout", 32'(arb_busy), 32'h0);
    chk("hsel_after_timeout", 32'(HSEL), 32'h0);
    @(negedge HCLK);
    set_req(0, 0, 32'h10, 32'h0, 3'b010); expect_xfer(0, 32'h10, 32'hDEADBEEF, 0, 5);
    drive(2'b01, 1); wait_done();

    // HRESP error on a write
    mode = 2;
    set_req(1, 1, 32'h30, 32'hCAFEF00D, 3'b010); expect_xfer(1, 32'h30, 32'h0, 1, 5);
    drive(2'b10, 1); wait_done();
    mode = 0;

    // reset in the middle of WAIT: no response, then requester 0 wins again
    lat = 10;
    set_req(0, 0, 32'h10, 32'h0, 3'b010); expect_xfer(0, 32'h10, 32'h0, 0, 99);
    drive(2'b01, 1);
    repeat (3) @(negedge HCLK);
    chk("mid_wait_busy", 32'(arb_busy), 32'h1);
    HRESET = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    exp_rsp.delete(); exp_gnt.delete();
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    lat = 2;
    set_req(0, 0, 32'h10, 32'h0, 3'b010);
    set_req(1, 0, 32'h20, 32'h0, 3'b010);
    expect_xfer(0, 32'h10, 32'hDEADBEEF, 0, 5);
    expect_xfer(1, 32'h20, 32'h11223344, 0, 5);
    drive(2'b11, 2); wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
